// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the FP divide sequencer and its operand classifier.
package fpu_div_pkg;

   typedef enum logic [1:0] {IDLE, RUN, RESP} div_state_e;
   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} op_class_e;

   localparam logic [1:0] SEL_DIV  = 2'b11;
   localparam logic [1:0] SEL_IDLE = 2'b00;

   localparam int DIV_CYCLES_DEF = 50;

   localparam logic [8:0]  EXP_ZERO    = 9'h000;
   localparam logic [8:0]  EXP_SPECIAL = 9'h0FF;
   localparam logic [48:0] MAN_ZERO    = 49'h0;
   localparam logic [48:0] MAN_QNAN    = 49'h0_8000_0000_0000;

endpackage

// File: rtl/fp_operand_class.sv
// Combinational IEEE-754 single magnitude classifier; subnormals count as NORM.
module fp_operand_class
   import fpu_div_pkg::*;
(
   input  logic [30:0] op_mag,
   output logic [1:0]  cls
);

   always_comb begin
      if (op_mag[30:23] == 8'hFF) begin
         cls = (op_mag[22:0] == 23'd0) ? INF : NAN;
      end else if (op_mag == 31'd0) begin
         cls = ZERO;
      end else begin
         cls = NORM;
      end
   end

endmodule

// File: rtl/fpu_div_ctrl.sv
// Sequencer around the iterative single-precision divider.
// Optional special-operand bypass: define FPU_DIV_SPECIAL_BYPASS_EN.
//
// state | meaning
// IDLE  | waiting for a request, divider deselected (count held at 0)
// RUN   | divider iterating on latched operands
// RESP  | result held on the response port until accepted or flushed
module fpu_div_ctrl
   import fpu_div_pkg::*;
#(
   parameter int TAG_W      = 5,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   input  logic             ext_stall,
   output logic [31:0]      div_a,
   output logic [31:0]      div_b,
   output logic [1:0]       div_sel,
   output logic             div_stall,
   input  logic             div_sign,
   input  logic [8:0]       div_exp,
   input  logic [48:0]      div_man,
   input  logic [5:0]       div_count,
   input  logic             div_done,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_sign,
   output logic [8:0]       resp_exp,
   output logic [48:0]      resp_man,
   output logic [TAG_W-1:0] resp_tag,
   output logic [1:0]       resp_flags,
   output logic             busy,
   output logic             seq_err
);

   localparam logic [5:0] CNT_MAX = 6'(DIV_CYCLES);

   div_state_e  state, state_nxt;
   logic        accept;
   logic        run_exit_q, run_exit_q2;
   logic        byp_hit;
   logic [8:0]  byp_exp;
   logic [48:0] byp_man;

   assign accept = (state == IDLE) && req_valid && !flush;
   assign busy   = (state != IDLE);

`ifdef FPU_DIV_SPECIAL_BYPASS_EN
   logic [1:0] cls_a, cls_b;
   logic [1:0] byp_flags;
   logic [1:0] flags_q;

   fp_operand_class u_cls_a (.op_mag(req_a[30:0]), .cls(cls_a));
   fp_operand_class u_cls_b (.op_mag(req_b[30:0]), .cls(cls_b));

   always_comb begin
      byp_hit   = 1'b1;
      byp_exp   = EXP_SPECIAL;
      byp_man   = MAN_ZERO;
      byp_flags = 2'b00;
      if (cls_a == NAN || cls_b == NAN || (cls_a == ZERO && cls_b == ZERO) ||
          (cls_a == INF && cls_b == INF)) begin
         byp_man   = MAN_QNAN;
         byp_flags = 2'b10;
      end else if (cls_a == NORM && cls_b == ZERO) begin
         byp_flags = 2'b01;
      end else if (cls_a == INF) begin
         byp_flags = 2'b00;
      end else if (cls_a == ZERO || cls_b == INF) begin
         byp_exp = EXP_ZERO;
      end else begin
         byp_hit = 1'b0;
      end
   end

   // Non-bypassed ops reload 00 at accept, so flags never leak between ops.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         flags_q <= 2'b00;
      end else if (accept) begin
         flags_q <= byp_hit ? byp_flags : 2'b00;
      end
   end

   assign resp_flags = flags_q;
`else
   assign byp_hit    = 1'b0;
   assign byp_exp    = EXP_ZERO;
   assign byp_man    = MAN_ZERO;
   assign resp_flags = 2'b00;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = byp_hit ? RESP : RUN;
         RUN:     if (flush) state_nxt = IDLE;
                  else if (div_done) state_nxt = RESP;
         RESP:    if (flush || resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      div_sel    = SEL_IDLE;
      div_stall  = 1'b0;
      resp_valid = 1'b0;
      unique case (state)
         IDLE:    req_ready = !flush;
         RUN: begin
            div_sel   = SEL_DIV;
            div_stall = ext_stall;
         end
         RESP:    resp_valid = 1'b1;
         default: ;
      endcase
   end

   // Divider clears its count one edge after sel drops, so the post-RUN
   // count check looks two cycles after the exit.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         div_a       <= '0;
         div_b       <= '0;
         resp_sign   <= 1'b0;
         resp_exp    <= '0;
         resp_man    <= '0;
         resp_tag    <= '0;
         seq_err     <= 1'b0;
         run_exit_q  <= 1'b0;
         run_exit_q2 <= 1'b0;
      end else begin
         run_exit_q  <= (state == RUN) && (state_nxt != RUN);
         run_exit_q2 <= run_exit_q;
         if (accept) begin
            div_a    <= req_a;
            div_b    <= req_b;
            resp_tag <= req_tag;
            if (byp_hit) begin
               resp_sign <= req_a[31] ^ req_b[31];
               resp_exp  <= byp_exp;
               resp_man  <= byp_man;
            end
         end
         if (state == RUN && div_done && !flush) begin
            resp_sign <= div_sign;
            resp_exp  <= div_exp;
            resp_man  <= div_man;
         end
         if ((state == RUN && div_count > CNT_MAX) ||
             (state != RUN && run_exit_q2 && div_count != 6'd0)) begin
            seq_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fpu_div_ctrl.sv
// Directed bench for fpu_div_ctrl with a behavioural divider count model.
module tb_fpu_div_ctrl;

   localparam int TAG_W = 5;

   logic             clk;
   logic             rstn;
   logic             req_valid, req_ready;
   logic [31:0]      req_a, req_b;
   logic [TAG_W-1:0] req_tag;
   logic             flush, ext_stall;
   logic [31:0]      div_a, div_b;
   logic [1:0]       div_sel;
   logic             div_stall;
   logic             m_sign;
   logic [8:0]       m_exp;
   logic [48:0]      m_man;
   logic [5:0]       div_count;
   logic             div_done;
   logic             resp_valid, resp_ready, resp_sign;
   logic [8:0]       resp_exp;
   logic [48:0]      resp_man;
   logic [TAG_W-1:0] resp_tag;
   logic [1:0]       resp_flags;
   logic             busy, seq_err;

   logic [5:0] cnt = 6'd0;
   logic       inj_en;
   logic [5:0] inj_val;

   int nvec  = 0;
   int nfail = 0;
   int edges = 0;

   fpu_div_ctrl #(.TAG_W(TAG_W), .DIV_CYCLES(50)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .flush(flush), .ext_stall(ext_stall),
      .div_a(div_a), .div_b(div_b), .div_sel(div_sel), .div_stall(div_stall),
      .div_sign(m_sign), .div_exp(m_exp), .div_man(m_man),
      .div_count(div_count), .div_done(div_done),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_sign(resp_sign), .resp_exp(resp_exp), .resp_man(resp_man),
      .resp_tag(resp_tag), .resp_flags(resp_flags),
      .busy(busy), .seq_err(seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divider count: clears when deselected, advances when selected and not stalled.
   always_ff @(posedge clk) begin
      if (div_sel != 2'b11) cnt <= 6'd0;
      else if (!div_stall && cnt < 6'd50) cnt <= cnt + 6'd1;
   end
   assign div_count = inj_en ? inj_val : cnt;
   assign div_done  = (cnt == 6'd50);

   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
      req_a = a; req_b = b; req_tag = t; req_valid = 1'b1;
      chk("req_ready_idle", 64'(req_ready), 64'(1));
      tick();
      req_valid = 1'b0;
      edges = 0;
   endtask

   task automatic wait_resp();
      while (resp_valid !== 1'b1 && edges < 200) tick();
      chk("resp_valid_rise", 64'(resp_valid), 64'(1));
   endtask

   initial begin
      rstn = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
      flush = 1'b0; ext_stall = 1'b0; resp_ready = 1'b1;
      m_sign = 1'b0; m_exp = 9'd128; m_man = 49'h1_8000_0000_0000;
      inj_en = 1'b0; inj_val = 6'd0;
      repeat (2) tick();
      chk("rst_div_sel", 64'(div_sel), 64'(0));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_seq_err", 64'(seq_err), 64'(0));
      chk("rst_div_a", 64'(div_a), 64'(0));
      rstn = 1'b1;
      tick();
      chk("idle_req_ready", 64'(req_ready), 64'(1));

      // 6.0 / 2.0, no stall
      send(32'h40C0_0000, 32'h4000_0000, 5'h0A);
      chk("run_sel", 64'(div_sel), 64'(2'b11));
      chk("run_busy", 64'(busy), 64'(1));
      chk("run_req_ready", 64'(req_ready), 64'(0));
      chk("run_div_a", 64'(div_a), 64'(32'h40C0_0000));
      chk("run_div_b", 64'(div_b), 64'(32'h4000_0000));
      wait_resp();
      chk("lat_nostall", 64'(edges), 64'(51));
      chk("t1_exp", 64'(resp_exp), 64'(128));
      chk("t1_man", 64'(resp_man), 64'(49'h1_8000_0000_0000));
      chk("t1_sign", 64'(resp_sign), 64'(0));
      chk("t1_tag", 64'(resp_tag), 64'(5'h0A));
      chk("t1_flags", 64'(resp_flags), 64'(0));
      chk("resp_sel_idle", 64'(div_sel), 64'(0));
      tick();
      chk("t1_back_idle", 64'(busy), 64'(0));
      chk("t1_valid_drop", 64'(resp_valid), 64'(0));

      // same op with 7 stall cycles mid-RUN
      send(32'h40C0_0000, 32'h4000_0000, 5'h0B);
      repeat (10) tick();
      ext_stall = 1'b1;
      tick();
      chk("stall_pass", 64'(div_stall), 64'(1));
      repeat (6) tick();
      ext_stall = 1'b0;
      chk("stall_div_a", 64'(div_a), 64'(32'h40C0_0000));
      chk("stall_div_b", 64'(div_b), 64'(32'h4000_0000));
      wait_resp();
      chk("lat_stall", 64'(edges), 64'(58));
      chk("stall_div_a_end", 64'(div_a), 64'(32'h40C0_0000));
      chk("t2_tag", 64'(resp_tag), 64'(5'h0B));
      tick();

      // flush at count 20
      send(32'h40C0_0000, 32'h4000_0000, 5'h0C);
      repeat (20) tick();
      chk("flush_cnt20", 64'(div_count), 64'(20));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_idle", 64'(busy), 64'(0));
      chk("flush_sel", 64'(div_sel), 64'(0));
      chk("flush_no_valid", 64'(resp_valid), 64'(0));
      tick();
      chk("flush_cnt_clear", 64'(div_count), 64'(0));
      chk("flush_no_valid2", 64'(resp_valid), 64'(0));
      m_exp = 9'd130; m_man = 49'h1_0000_0000_0000;
      send(32'h4100_0000, 32'h3F80_0000, 5'h0D);
      wait_resp();
      chk("after_flush_lat", 64'(edges), 64'(51));
      chk("after_flush_exp", 64'(resp_exp), 64'(130));
      chk("after_flush_tag", 64'(resp_tag), 64'(5'h0D));
      tick();

      // response backpressure for 10 cycles
      resp_ready = 1'b0;
      m_sign = 1'b1; m_exp = 9'h07F; m_man = 49'h0_1234_5678_9ABC;
      send(32'hBF80_0000, 32'h3F80_0000, 5'h11);
      wait_resp();
      m_sign = 1'b0; m_exp = 9'h1AA; m_man = 49'h0;
      req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("hold_exp", 64'(resp_exp), 64'(9'h07F));
         chk("hold_man", 64'(resp_man), 64'(49'h0_1234_5678_9ABC));
         chk("hold_sign", 64'(resp_sign), 64'(1));
         chk("hold_req_ready", 64'(req_ready), 64'(0));
         tick();
      end
      req_valid = 1'b0;
      chk("hold_valid", 64'(resp_valid), 64'(1));
      chk("hold_tag", 64'(resp_tag), 64'(5'h11));
      resp_ready = 1'b1;
      tick();
      chk("release_idle", 64'(busy), 64'(0));
      chk("release_req_ready", 64'(req_ready), 64'(1));
      chk("release_valid", 64'(resp_valid), 64'(0));

      // reset at count 30
      m_sign = 1'b0; m_exp = 9'd128; m_man = 49'h1_8000_0000_0000;
      send(32'h40C0_0000, 32'h4000_0000, 5'h15);
      repeat (30) tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("mrst_sel", 64'(div_sel), 64'(0));
      chk("mrst_div_a", 64'(div_a), 64'(0));
      chk("mrst_div_b", 64'(div_b), 64'(0));
      chk("mrst_exp", 64'(resp_exp), 64'(0));
      chk("mrst_man", 64'(resp_man), 64'(0));
      chk("mrst_sign", 64'(resp_sign), 64'(0));
      chk("mrst_tag", 64'(resp_tag), 64'(0));
      chk("mrst_busy", 64'(busy), 64'(0));
      chk("mrst_valid", 64'(resp_valid), 64'(0));
      repeat (4) tick();
      chk("mrst_seq_err", 64'(seq_err), 64'(0));

`ifdef FPU_DIV_SPECIAL_BYPASS_EN
      // special operands bypass the divider
      send(32'h3F80_0000, 32'h0000_0000, 5'h02);
      chk("byp_dz_sel", 64'(div_sel), 64'(0));
      chk("byp_dz_valid", 64'(resp_valid), 64'(1));
      chk("byp_dz_exp", 64'(resp_exp), 64'(9'h0FF));
      chk("byp_dz_man", 64'(resp_man), 64'(0));
      chk("byp_dz_flags", 64'(resp_flags), 64'(2'b01));
      chk("byp_dz_sign", 64'(resp_sign), 64'(0));
      tick();
      send(32'h0000_0000, 32'h0000_0000, 5'h03);
      chk("byp_nan_sel", 64'(div_sel), 64'(0));
      chk("byp_nan_valid", 64'(resp_valid), 64'(1));
      chk("byp_nan_exp", 64'(resp_exp), 64'(9'h0FF));
      chk("byp_nan_man", 64'(resp_man), 64'(49'h0_8000_0000_0000));
      chk("byp_nan_flags", 64'(resp_flags), 64'(2'b10));
      tick();
`else
      // without bypass, 1.0/0.0 goes through the divider
      send(32'h3F80_0000, 32'h0000_0000, 5'h02);
      chk("nobyp_sel", 64'(div_sel), 64'(2'b11));
      wait_resp();
      chk("nobyp_lat", 64'(edges), 64'(51));
      chk("nobyp_flags", 64'(resp_flags), 64'(0));
      tick();
`endif

      // count overrun flags seq_err, sticky until reset
      send(32'h40C0_0000, 32'h4000_0000, 5'h07);
      repeat (5) tick();
      inj_en = 1'b1; inj_val = 6'd55;
      tick();
      inj_en = 1'b0;
      chk("seq_err_set", 64'(seq_err), 64'(1));
      wait_resp();
      tick();
      chk("seq_err_sticky", 64'(seq_err), 64'(1));
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("seq_err_clear", 64'(seq_err), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
